sim_pipelined_memory: RTL and testbench

//   Unsynthesisable, simulation-only word-addressed memory with a valid/ready request channel,
//   a tagged response channel, programmable fixed latency, byte-strobe writes and bounded

---
 rtl/sim_mem_pkg.sv | 33 +++
 rtl/sim_mem_rsp_fifo.sv | 93 +++++++++
 rtl/sim_pipelined_memory.sv | 183 ++++++++++++++++++
 tb/tb_sim_pipelined_memory.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_mem_pkg.sv
// ----------------------------------------------------------------------------
// sim_mem_pkg
//   Shared types and constants for the pipelined simulation memory model.
//   rsp_t is the record carried through the latency pipeline and the
//   response FIFO: read data, echoed tag, write flag and address-error flag.
//   The default widths here are also the parameter defaults of the top level.
// ----------------------------------------------------------------------------
package sim_mem_pkg;

    localparam int MEM_ADDR_W     = 20;
    localparam int MEM_DATA_BYTES = 8;
    localparam int MEM_DATA_W     = MEM_DATA_BYTES * 8;
    localparam int MEM_TAG_W      = 4;

    // Legal ranges for the timing/occupancy parameters.
    localparam int LATENCY_MIN   = 1;
    localparam int LATENCY_MAX   = 16;
    localparam int MAX_OUTST_MIN = 1;
    localparam int MAX_OUTST_MAX = 32;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  tag;
        logic                  write;
        logic                  err;
    } rsp_t;

    // Pointer width that stays at least one bit for single-entry structures.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_mem_rsp_fifo.sv
// ----------------------------------------------------------------------------
// sim_mem_rsp_fifo
//   Count-based response FIFO with a fall-through head. When empty, an
//   incoming entry is presented on the head in the same cycle and, if popped,
//   bypasses storage entirely. The caller guarantees it never pushes into a
//   full FIFO (occupancy is bounded upstream).
// Ports
//   clk           in   clock
//   rst_n         in   synchronous active-low reset (empties the FIFO)
//   push_valid_i  in   entry arriving from the latency pipeline
//   push_data_i   in   entry payload
//   head_valid_o  out  an entry is available at the head
//   head_data_o   out  head payload
//   pop_i         in   head is consumed this cycle
// ----------------------------------------------------------------------------
module sim_mem_rsp_fifo
    import sim_mem_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid_i,
    input  rsp_t push_data_i,
    output logic head_valid_o,
    output rsp_t head_data_o,
    input  logic pop_i
);

    localparam int PTR_W = clog2_min1(N_ENTRIES);
    localparam int CNT_W = $clog2(N_ENTRIES + 1);

    rsp_t             mem_q [N_ENTRIES];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic bypass;
    logic do_write;
    logic do_read;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign head_valid_o = !empty || push_valid_i;
    assign head_data_o  = empty ? push_data_i : mem_q[rd_ptr_q];

    // An entry consumed in the cycle it arrives into an empty FIFO never
    // occupies a slot.
    assign bypass   = empty && push_valid_i && pop_i;
    assign do_write = push_valid_i && !bypass;
    assign do_read  = pop_i && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_read) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_write && !do_read) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_write && do_read) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: validity lives in count_q.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sim_pipelined_memory.sv
// ----------------------------------------------------------------------------
// sim_pipelined_memory
//   Word-addressed memory model with a valid/ready request channel, a tagged
//   in-order response channel, fixed latency, byte-strobe writes and a bound
//   on outstanding requests. Intended to sit behind a cache/LSU memory port in
//   testbenches.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_write, req_addr        1 = write / word address
//   req_wdata, req_wstrb       write data / per-byte write enable
//   req_tag                    caller tag, echoed on the response
//   rsp_valid / rsp_ready      response handshake
//   rsp_data                   read data (0 for writes and errors)
//   rsp_tag, rsp_write         tag and write flag of the originating request
//   rsp_err                    address was >= DEPTH
//
// Handshakes: a transfer happens on a posedge where valid & ready are both
// high. A producer holding valid while ready is low keeps its payload stable
// until the transfer; ready may change freely and never depends on valid.
// ----------------------------------------------------------------------------
module sim_pipelined_memory
    import sim_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_BYTES = MEM_DATA_BYTES,
    parameter int DEPTH      = 65536,
    parameter int LATENCY    = 4,
    parameter int MAX_OUTST  = 8,
    parameter int TAG_W      = MEM_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_BYTES*8-1:0] req_wdata,
    input  logic [DATA_BYTES-1:0]   req_wstrb,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BYTES*8-1:0] rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    rsp_write,
    output logic                    rsp_err
);

    localparam int DATA_W = DATA_BYTES * 8;
    localparam int IDX_W  = clog2_min1(DEPTH);
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    // Wide enough to compare any address against DEPTH without truncation.
    localparam int CMP_W  = ADDR_W + 33;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("sim_pipelined_memory: LATENCY out of range 1..16");
    end
    if (MAX_OUTST < MAX_OUTST_MIN || MAX_OUTST > MAX_OUTST_MAX) begin : g_bad_outst
        $error("sim_pipelined_memory: MAX_OUTST out of range 1..32");
    end
    if (DATA_BYTES != MEM_DATA_BYTES || TAG_W != MEM_TAG_W) begin : g_bad_width
        $error("sim_pipelined_memory: DATA_BYTES/TAG_W must match sim_mem_pkg");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sim_pipelined_memory: DEPTH must be a power of two");
    end

    // Storage is deliberately left out of reset so data survives a reset.
    logic [DATA_W-1:0] storage_q [DEPTH];

    logic             accept;
    logic             retire;
    logic             addr_err;
    logic [IDX_W-1:0] mem_idx;
    logic             wr_en;
    rsp_t             new_rsp;

    logic [LATENCY-1:0] pipe_valid_q;
    rsp_t               pipe_rsp_q [LATENCY];

    logic [CNT_W-1:0] outst_q, outst_d;

    logic head_valid;
    rsp_t head_rsp;

    // Ready comes only from the registered count, so a retire in the same
    // cycle as a full condition frees a slot one cycle later.
    assign req_ready = rst_n && (outst_q < CNT_W'(MAX_OUTST));
    assign accept    = req_valid && req_ready;
    assign retire    = rsp_valid && rsp_ready;

    assign addr_err = (CMP_W'(req_addr) >= CMP_W'(DEPTH));
    assign mem_idx  = IDX_W'(req_addr);
    assign wr_en    = accept && req_write && !addr_err;

    // Read data is captured at the accept edge, so later writes cannot
    // disturb a read already in flight.
    always_comb begin
        new_rsp       = '0;
        new_rsp.tag   = req_tag;
        new_rsp.write = req_write;
        new_rsp.err   = addr_err;
        if (!req_write && !addr_err) begin
            new_rsp.data = storage_q[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (req_wstrb[b]) begin
                    storage_q[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Fixed-latency shift pipeline; it never stalls because the FIFO behind
    // it always has room for everything counted in outst_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q[0] <= accept;
            for (int s = 1; s < LATENCY; s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_rsp_q[0] <= new_rsp;
        for (int s = 1; s < LATENCY; s++) begin
            pipe_rsp_q[s] <= pipe_rsp_q[s-1];
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (accept && !retire) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!accept && retire) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    sim_mem_rsp_fifo #(
        .N_ENTRIES (MAX_OUTST)
    ) u_rsp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (pipe_valid_q[LATENCY-1]),
        .push_data_i  (pipe_rsp_q[LATENCY-1]),
        .head_valid_o (head_valid),
        .head_data_o  (head_rsp),
        .pop_i        (retire)
    );

    // Outputs are forced to zero whenever no response is presented.
    assign rsp_valid = rst_n && head_valid;
    assign rsp_data  = rsp_valid ? head_rsp.data  : '0;
    assign rsp_tag   = rsp_valid ? head_rsp.tag   : '0;
    assign rsp_write = rsp_valid ? head_rsp.write : 1'b0;
    assign rsp_err   = rsp_valid ? head_rsp.err   : 1'b0;

    // Requester protocol checks.
    a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && !req_ready) |=>
            (req_valid && $stable(req_write) && $stable(req_addr) &&
             $stable(req_wdata) && $stable(req_wstrb) && $stable(req_tag)));

    a_req_valid_known : assert property (@(posedge clk)
        rst_n |-> !$isunknown(req_valid));

endmodule

// File: tb/tb_sim_pipelined_memory.sv
module tb_sim_pipelined_memory;

    localparam int ADDR_W     = 20;
    localparam int DATA_BYTES = 8;
    localparam int DATA_W     = 64;
    localparam int DEPTH      = 65536;
    localparam int LATENCY    = 4;
    localparam int MAX_OUTST  = 8;
    localparam int TAG_W      = 4;
    localparam int RSP_W      = DATA_W + TAG_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_BYTES-1:0] req_wstrb;
    logic [TAG_W-1:0]      req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_write;
    logic                  rsp_err;

    sim_pipelined_memory #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY),
        .MAX_OUTST  (MAX_OUTST),
        .TAG_W      (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [RSP_W-1:0] exp_q[$];
    int               ret_q[$];
    logic             hold_pend = 1'b0;
    logic [RSP_W-1:0] held;
    logic [RSP_W-1:0] mon_cur;

    task automatic expect_rsp(input logic [DATA_W-1:0] data, input logic [TAG_W-1:0] tag,
                              input logic wr, input logic err);
        exp_q.push_back({data, tag, wr, err});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            mon_cur = {rsp_data, rsp_tag, rsp_write, rsp_err};
            if (hold_pend) begin
                check_eq("rsp_hold_valid", rsp_valid, 1'b1);
                check_eq("rsp_hold_payload", mon_cur, held);
            end
            hold_pend = rsp_valid && !rsp_ready;
            held      = mon_cur;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid, 1'b0);
                else                   check_eq("rsp", mon_cur, exp_q.pop_front());
                ret_q.push_back(cyc + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DATA_BYTES-1:0] strb,
                             input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        req_tag   = tag;
    endtask

    // Returns the posedge count at which the request was accepted.
    task automatic send(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_BYTES-1:0] strb,
                        input logic [TAG_W-1:0] tag, output int acc);
        drive_req(wr, addr, wdata, strb, tag);
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) check_eq("req_accept_timeout", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        step();
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int acc, acc_w, acc_r, acc0, acc7, rel;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;

        // 1: reset
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_req_ready", req_ready, 1'b0);
            check_eq("rst_rsp_valid", rsp_valid, 1'b0);
            check_eq("rst_rsp_data", rsp_data, 64'h0);
            check_eq("rst_rsp_tag", rsp_tag, 4'h0);
            check_eq("rst_rsp_write", rsp_write, 1'b0);
            check_eq("rst_rsp_err", rsp_err, 1'b0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_ready", req_ready, 1'b1);
        check_eq("post_rst_rsp_valid", rsp_valid, 1'b0);
        step();

        // 2: write then read-next-cycle, latency and tag echo
        ret_q.delete();
        expect_rsp(64'h0, 4'h1, 1'b1, 1'b0);
        send(1'b1, 20'h00010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 4'h1, acc_w);
        expect_rsp(64'hDEADBEEF_CAFEF00D, 4'h2, 1'b0, 1'b0);
        send(1'b0, 20'h00010, 64'h0, 8'h00, 4'h2, acc_r);
        wait_drain();
        check_eq("t2_back_to_back", acc_r, acc_w + 1);
        check_eq("t2_ret_count", ret_q.size(), 2);
        if (ret_q.size() >= 2) begin
            check_eq("t2_wr_latency", ret_q[0], acc_w + 4);
            check_eq("t2_rd_latency", ret_q[1], acc_w + 5);
        end

        // 3: byte strobes
        expect_rsp(64'h0, 4'h3, 1'b1, 1'b0);
        send(1'b1, 20'h00020, 64'h11223344_55667788, 8'hFF, 4'h3, acc);
        expect_rsp(64'h0, 4'h4, 1'b1, 1'b0);
        send(1'b1, 20'h00020, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 4'h4, acc);
        expect_rsp(64'h11223344_FFFFFFFF, 4'h5, 1'b0, 1'b0);
        send(1'b0, 20'h00020, 64'h0, 8'h00, 4'h5, acc);
        expect_rsp(64'h0, 4'h6, 1'b1, 1'b0);
        send(1'b1, 20'h00020, 64'h0, 8'h00, 4'h6, acc);
        expect_rsp(64'h11223344_FFFFFFFF, 4'h7, 1'b0, 1'b0);
        send(1'b0, 20'h00020, 64'h0, 8'h00, 4'h7, acc);
        expect_rsp(64'h0, 4'h8, 1'b1, 1'b0);
        send(1'b1, 20'h00020, 64'hA5A5A5A5_A5A5A5A5, 8'h81, 4'h8, acc);
        expect_rsp(64'hA5223344_FFFFFFA5, 4'h9, 1'b0, 1'b0);
        send(1'b0, 20'h00020, 64'h0, 8'h00, 4'h9, acc);
        wait_drain();

        // 5: address errors and the top legal word
        expect_rsp(64'h0, 4'h1, 1'b1, 1'b0);
        send(1'b1, 20'h00005, 64'h55555555_55555555, 8'hFF, 4'h1, acc);
        expect_rsp(64'h0, 4'h2, 1'b0, 1'b1);
        send(1'b0, 20'h10000, 64'h0, 8'h00, 4'h2, acc);
        expect_rsp(64'h0, 4'h3, 1'b1, 1'b1);
        send(1'b1, 20'h10005, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 4'h3, acc);
        expect_rsp(64'h55555555_55555555, 4'h4, 1'b0, 1'b0);
        send(1'b0, 20'h00005, 64'h0, 8'h00, 4'h4, acc);
        expect_rsp(64'h0, 4'h5, 1'b1, 1'b0);
        send(1'b1, 20'h0FFFF, 64'h0BADF00D_0000FFFF, 8'hFF, 4'h5, acc);
        expect_rsp(64'h0BADF00D_0000FFFF, 4'h6, 1'b0, 1'b0);
        send(1'b0, 20'h0FFFF, 64'h0, 8'h00, 4'h6, acc);
        wait_drain();

        // 4: backpressure and outstanding limit
        for (int i = 0; i < 10; i++) begin
            expect_rsp(64'h0, TAG_W'(i), 1'b1, 1'b0);
            send(1'b1, 20'h00100 + ADDR_W'(i), pat(i), 8'hFF, TAG_W'(i), acc);
        end
        wait_drain();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_rsp(pat(i), TAG_W'(i), 1'b0, 1'b0);
            send(1'b0, 20'h00100 + ADDR_W'(i), 64'h0, 8'h00, TAG_W'(i), acc);
            if (i == 0) acc0 = acc;
            if (i == 7) acc7 = acc;
        end
        check_eq("t4_burst_span", acc7 - acc0, 7);
        drive_req(1'b0, 20'h00108, 64'h0, 8'h00, 4'h8);
        repeat (3) @(negedge clk);
        check_eq("t4_full_ready", req_ready, 1'b0);
        check_eq("t4_rsp_waiting", rsp_valid, 1'b1);
        check_eq("t4_head_tag", rsp_tag, 4'h0);
        step();
        rsp_ready = 1'b1;
        rel = cyc;
        expect_rsp(pat(8), 4'h8, 1'b0, 1'b0);
        send(1'b0, 20'h00108, 64'h0, 8'h00, 4'h8, acc);
        check_eq("t4_ready_after_retire", acc, rel + 2);
        expect_rsp(pat(9), 4'h9, 1'b0, 1'b0);
        send(1'b0, 20'h00109, 64'h0, 8'h00, 4'h9, acc);
        wait_drain();

        // 6: reset with reads in flight
        expect_rsp(64'h0, 4'h1, 1'b1, 1'b0);
        send(1'b1, 20'h00030, 64'h66666666_77777777, 8'hFF, 4'h1, acc);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 20'h00030, 64'h0, 8'h00, TAG_W'(i + 2), acc);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("t6_rst_req_ready", req_ready, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t6_no_stale", rsp_valid, 1'b0);
        end
        step();
        expect_rsp(64'h66666666_77777777, 4'h7, 1'b0, 1'b0);
        send(1'b0, 20'h00030, 64'h0, 8'h00, 4'h7, acc);
        wait_drain();
        // A full window must fit again, so the count really restarted at zero.
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_rsp(pat(i), TAG_W'(i + 8), 1'b0, 1'b0);
            send(1'b0, 20'h00100 + ADDR_W'(i), 64'h0, 8'h00, TAG_W'(i + 8), acc);
        end
        @(negedge clk);
        check_eq("t6_full_again", req_ready, 1'b0);
        step();
        rsp_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
